// File: rtl/bg_band_sequencer.sv
// Horizontal-band background scheduler: double-buffered band table (end line, colour),
// per-line scan during hblank and vblank-synchronised shadow-to-active commit.
module bg_band_sequencer #(
    parameter int BANDS = 16,
    parameter int IW    = $clog2(BANDS)
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic [11:0]   vcount_in,
    input  logic          hblnk_in,
    input  logic          vblnk_in,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [IW-1:0] cfg_idx,
    input  logic [11:0]   cfg_end,
    input  logic [11:0]   cfg_rgb,
    input  logic          cfg_commit,
    output logic          commit_done,
    output logic [11:0]   line_rgb,
    output logic          line_rgb_valid
);

    localparam logic [1:0] CFG_IDLE    = 2'd0;
    localparam logic [1:0] CFG_PENDING = 2'd1;
    localparam logic [1:0] CFG_COPY    = 2'd2;
    localparam logic [0:0] SCN_IDLE    = 1'b0;
    localparam logic [0:0] SCN_SCAN    = 1'b1;

    // Power-on table as {end line, colour}
    function automatic logic [23:0] default_entry(input int i);
        case (i)
            0:       return {12'd6,    12'h3BE};
            1:       return {12'd12,   12'h6CF};
            2:       return {12'd20,   12'h3BE};
            3:       return {12'd28,   12'h6CF};
            4:       return {12'd462,  12'h7AD};
            5:       return {12'd474,  12'hBDF};
            6:       return {12'd483,  12'h05A};
            7:       return {12'd512,  12'h28D};
            8:       return {12'd576,  12'h9CE};
            9:       return {12'd586,  12'h7AD};
            10:      return {12'd594,  12'hFFF};
            11:      return {12'd614,  12'h974};
            12:      return {12'd670,  12'hC96};
            default: return {12'd4095, 12'hEC9};
        endcase
    endfunction

    logic [11:0]   r_act_end [BANDS];
    logic [11:0]   r_act_rgb [BANDS];
    logic [11:0]   r_shd_end [BANDS];
    logic [11:0]   r_shd_rgb [BANDS];
    logic          r_hblnk_d;
    logic          r_vblnk_d;
    logic          r_fpre;
    logic [1:0]    r_cfg_state;
    logic [IW-1:0] r_copy_idx;
    logic          r_cfg_ready;
    logic          r_commit_done;
    logic [0:0]    r_scan_state;
    logic [IW-1:0] r_scan_idx;
    logic [11:0]   r_target;
    logic [11:0]   r_line_rgb;
    logic          r_line_rgb_valid;

    logic w_h_rise;
    logic w_v_rise;
    logic w_wr_accept;
    logic w_commit_accept;
    logic w_copying;
    logic w_copy_last;
    logic w_trig_f;
    logic w_hit;

    assign w_h_rise        = hblnk_in & ~r_hblnk_d & ~vblnk_in;
    assign w_v_rise        = vblnk_in & ~r_vblnk_d;
    assign w_wr_accept     = cfg_valid & r_cfg_ready & (r_cfg_state == CFG_IDLE);
    assign w_commit_accept = cfg_commit & r_cfg_ready & (r_cfg_state == CFG_IDLE);
    assign w_copying       = (r_cfg_state == CFG_COPY);
    assign w_copy_last     = w_copying & (r_copy_idx == IW'(BANDS - 1));
    assign w_trig_f        = w_copy_last | r_fpre;
    assign w_hit           = (r_target <= r_act_end[r_scan_idx]) | (r_scan_idx == IW'(BANDS - 1));

    assign cfg_ready      = r_cfg_ready;
    assign commit_done    = r_commit_done;
    assign line_rgb       = r_line_rgb;
    assign line_rgb_valid = r_line_rgb_valid;

    // Blank edge history and the idle-frame prescan request
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_hblnk_d <= 1'b0;
            r_vblnk_d <= 1'b0;
            r_fpre    <= 1'b0;
        end else begin
            r_hblnk_d <= hblnk_in;
            r_vblnk_d <= vblnk_in;
            r_fpre    <= w_v_rise & (r_cfg_state == CFG_IDLE);
        end
    end

    // Shadow bank: host writes; out-of-range indices are dropped
    always_ff @(posedge pclk) begin
        if (rst) begin
            for (int i = 0; i < BANDS; i++) begin
                {r_shd_end[i], r_shd_rgb[i]} <= default_entry(i);
            end
        end else if (w_wr_accept && (int'(cfg_idx) < BANDS)) begin
            r_shd_end[cfg_idx] <= cfg_end;
            r_shd_rgb[cfg_idx] <= cfg_rgb;
        end
    end

    // Active bank: one entry per cycle copied from shadow during COPY
    always_ff @(posedge pclk) begin
        if (rst) begin
            for (int i = 0; i < BANDS; i++) begin
                {r_act_end[i], r_act_rgb[i]} <= default_entry(i);
            end
        end else if (w_copying) begin
            r_act_end[r_copy_idx] <= r_shd_end[r_copy_idx];
            r_act_rgb[r_copy_idx] <= r_shd_rgb[r_copy_idx];
        end
    end

    // Config FSM: commit waits for a vblank rising edge, then copies the whole table
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_cfg_state   <= CFG_IDLE;
            r_copy_idx    <= '0;
            r_cfg_ready   <= 1'b0;
            r_commit_done <= 1'b0;
        end else begin
            r_commit_done <= 1'b0;
            // Low through the done cycle, high again the cycle after it
            r_cfg_ready   <= (r_cfg_state == CFG_IDLE) & ~w_commit_accept;
            case (r_cfg_state)
                CFG_IDLE: begin
                    if (w_commit_accept) r_cfg_state <= CFG_PENDING;
                end
                CFG_PENDING: begin
                    if (w_v_rise) begin
                        r_cfg_state <= CFG_COPY;
                        r_copy_idx  <= '0;
                    end
                end
                CFG_COPY: begin
                    if (w_copy_last) begin
                        r_cfg_state   <= CFG_IDLE;
                        r_copy_idx    <= '0;
                        r_commit_done <= 1'b1;
                    end else begin
                        r_copy_idx <= r_copy_idx + IW'(1);
                    end
                end
                default: r_cfg_state <= CFG_IDLE;
            endcase
        end
    end

    // Scanner: first entry whose end covers the target wins; new triggers restart it
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_scan_state     <= SCN_IDLE;
            r_scan_idx       <= '0;
            r_target         <= 12'd0;
            r_line_rgb       <= 12'h000;
            r_line_rgb_valid <= 1'b0;
        end else begin
            r_line_rgb_valid <= 1'b0;
            if (w_trig_f) begin
                r_scan_state <= SCN_SCAN;
                r_scan_idx   <= '0;
                r_target     <= 12'd0;
            end else if (w_copying) begin
                // Active bank is mid-copy; the completion prescan replaces this scan
                r_scan_state <= SCN_IDLE;
            end else if (w_h_rise) begin
                r_scan_state <= SCN_SCAN;
                r_scan_idx   <= '0;
                r_target     <= vcount_in + 12'd1;
            end else begin
                case (r_scan_state)
                    SCN_IDLE: r_scan_state <= SCN_IDLE;
                    SCN_SCAN: begin
                        if (w_hit) begin
                            r_line_rgb       <= r_act_rgb[r_scan_idx];
                            r_line_rgb_valid <= 1'b1;
                            r_scan_state     <= SCN_IDLE;
                        end else begin
                            r_scan_idx <= r_scan_idx + IW'(1);
                        end
                    end
                    default: r_scan_state <= SCN_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bg_band_sequencer.sv
// Directed plus randomized bench for bg_band_sequencer against a table-lookup model.
module tb_bg_band_sequencer;

    localparam int BANDS = 16;
    localparam int IW    = 4;
    localparam logic [11:0] DEF_END [14] = '{12'd6, 12'd12, 12'd20, 12'd28, 12'd462, 12'd474, 12'd483,
                                             12'd512, 12'd576, 12'd586, 12'd594, 12'd614, 12'd670, 12'd4095};
    localparam logic [11:0] DEF_RGB [14] = '{12'h3BE, 12'h6CF, 12'h3BE, 12'h6CF, 12'h7AD, 12'hBDF, 12'h05A,
                                             12'h28D, 12'h9CE, 12'h7AD, 12'hFFF, 12'h974, 12'hC96, 12'hEC9};

    logic          pclk = 1'b0;
    logic          rst = 1'b1;
    logic [11:0]   vcount_in = 12'd0;
    logic          hblnk_in = 1'b0;
    logic          vblnk_in = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [IW-1:0] cfg_idx = '0;
    logic [11:0]   cfg_end = 12'd0;
    logic [11:0]   cfg_rgb = 12'd0;
    logic          cfg_commit = 1'b0;
    logic          commit_done;
    logic [11:0]   line_rgb;
    logic          line_rgb_valid;

    int tests = 0;
    int fails = 0;

    logic [11:0] m_act_end [BANDS];
    logic [11:0] m_act_rgb [BANDS];
    logic [11:0] m_shd_end [BANDS];
    logic [11:0] m_shd_rgb [BANDS];

    bg_band_sequencer #(.BANDS(BANDS)) dut (
        .pclk(pclk), .rst(rst), .vcount_in(vcount_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx), .cfg_end(cfg_end),
        .cfg_rgb(cfg_rgb), .cfg_commit(cfg_commit), .commit_done(commit_done),
        .line_rgb(line_rgb), .line_rgb_valid(line_rgb_valid)
    );

    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < BANDS; i++) begin
            m_act_end[i] = (i < 14) ? DEF_END[i] : 12'd4095;
            m_act_rgb[i] = (i < 14) ? DEF_RGB[i] : 12'hEC9;
            m_shd_end[i] = m_act_end[i];
            m_shd_rgb[i] = m_act_rgb[i];
        end
    endtask

    function automatic int find_idx(input logic [11:0] t);
        for (int i = 0; i < BANDS; i++) if (t <= m_act_end[i]) return i;
        return BANDS - 1;
    endfunction

    // Raise hblank for line v, expect one valid pulse with the model colour after k+2 clocks
    task automatic scan_line(input logic [11:0] v, input string tag);
        int k; int n; logic got; logic [11:0] t;
        t = v + 12'd1;
        k = find_idx(t);
        n = 0; got = 1'b0;
        vcount_in = v;
        hblnk_in = 1'b1;
        for (int c = 1; c <= BANDS + 4 && !got; c++) begin
            tick();
            if (line_rgb_valid) begin got = 1'b1; n = c; end
        end
        check({tag, "_valid"}, 32'(got), 32'd1);
        check({tag, "_lat"}, n, k + 2);
        check({tag, "_rgb"}, 32'(line_rgb), 32'(m_act_rgb[k]));
        tick();
        check({tag, "_pulse"}, 32'(line_rgb_valid), 32'd0);
        hblnk_in = 1'b0;
        tick(); tick();
    endtask

    task automatic write_cfg(input logic v, input int idx, input logic [11:0] e, input logic [11:0] rgb,
                             input logic cm, input string tag);
        for (int c = 0; c < 40 && !cfg_ready; c++) tick();
        check({tag, "_ready"}, 32'(cfg_ready), 32'd1);
        cfg_valid = v; cfg_idx = IW'(idx); cfg_end = e; cfg_rgb = rgb; cfg_commit = cm;
        tick();
        cfg_valid = 1'b0; cfg_commit = 1'b0;
        if (v && idx < BANDS) begin
            m_shd_end[idx] = e;
            m_shd_rgb[idx] = rgb;
        end
    endtask

    // Rising vblank with a commit pending: check copy length, ready timing and the prescan result
    task automatic vblank_copy(input string tag);
        int n; int m; int k; logic got;
        n = 0; m = 0; got = 1'b0;
        vblnk_in = 1'b1;
        for (int c = 1; c <= 2 * BANDS + 8 && n == 0; c++) begin
            tick();
            if (commit_done) n = c;
        end
        check({tag, "_done_lat"}, n, BANDS + 1);
        check({tag, "_ready_done"}, 32'(cfg_ready), 32'd0);
        for (int i = 0; i < BANDS; i++) begin
            m_act_end[i] = m_shd_end[i];
            m_act_rgb[i] = m_shd_rgb[i];
        end
        k = find_idx(12'd0);
        for (int c = 1; c <= BANDS + 4 && !got; c++) begin
            tick();
            if (c == 1) check({tag, "_ready_after"}, 32'(cfg_ready), 32'd1);
            if (c == 1) check({tag, "_done_pulse"}, 32'(commit_done), 32'd0);
            if (line_rgb_valid) begin got = 1'b1; m = c; end
        end
        check({tag, "_pre_lat"}, m, k + 1);
        check({tag, "_pre_rgb"}, 32'(line_rgb), 32'(m_act_rgb[k]));
        vblnk_in = 1'b0;
        tick(); tick();
    endtask

    initial begin
        int pulses; logic seen; logic [11:0] v;
        model_reset();

        // Reset state
        tick(); tick(); tick();
        check("rst_ready", 32'(cfg_ready), 32'd0);
        check("rst_done", 32'(commit_done), 32'd0);
        check("rst_rgb", 32'(line_rgb), 32'h000);
        check("rst_valid", 32'(line_rgb_valid), 32'd0);
        rst = 1'b0;
        tick();
        check("ready_after_rst", 32'(cfg_ready), 32'd1);

        // Default table lookups
        scan_line(12'd5, "scan5");
        scan_line(12'd462, "scan462");
        scan_line(12'd700, "scan700");
        scan_line(12'd4095, "scan_wrap");
        for (int i = 0; i < 4; i++) begin
            v = 12'($urandom_range(0, 4095));
            scan_line(v, "scan_rand_def");
        end

        // Shadow write is invisible until committed
        write_cfg(1'b1, 0, 12'd100, 12'hF00, 1'b0, "wr0");
        scan_line(12'd50, "scan50_pre");
        write_cfg(1'b0, 0, 12'd0, 12'd0, 1'b1, "commit1");
        vblank_copy("copy1");
        scan_line(12'd50, "scan50_post");

        // Commit while vblank already high waits for the next rising edge; PENDING rejects writes
        vblnk_in = 1'b1;
        for (int c = 0; c < 25; c++) tick();
        check("vb_prescan_rgb", 32'(line_rgb), 32'(m_act_rgb[find_idx(12'd0)]));
        write_cfg(1'b0, 0, 12'd0, 12'd0, 1'b1, "commit2");
        cfg_valid = 1'b1; cfg_idx = '0; cfg_end = 12'd10; cfg_rgb = 12'hABC;
        check("pending_ready", 32'(cfg_ready), 32'd0);
        tick();
        cfg_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (commit_done) seen = 1'b1;
        end
        check("pending_no_copy", 32'(seen), 32'd0);
        vblnk_in = 1'b0;
        tick(); tick();
        vblank_copy("copy2");

        // Write and commit in the same cycle
        write_cfg(1'b1, 0, 12'd20, 12'h111, 1'b0, "wr0b");
        write_cfg(1'b1, 1, 12'd40, 12'h0F0, 1'b1, "wr1_commit");
        vblank_copy("copy3");
        scan_line(12'd30, "scan30");

        // Second hblank rise three cycles into a long scan: single pulse, second colour
        vcount_in = 12'd700; hblnk_in = 1'b1;
        tick(); tick();
        hblnk_in = 1'b0;
        tick();
        vcount_in = 12'd5; hblnk_in = 1'b1;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (line_rgb_valid) begin
                pulses++;
                check("abort_rgb", 32'(line_rgb), 32'(m_act_rgb[find_idx(12'd6)]));
            end
        end
        check("abort_pulses", pulses, 1);
        hblnk_in = 1'b0;
        tick();

        // hblank edges inside vblank are ignored
        vblnk_in = 1'b1;
        for (int c = 0; c < 25; c++) tick();
        vcount_in = 12'd30; hblnk_in = 1'b1;
        pulses = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (line_rgb_valid) pulses++;
        end
        check("vb_hblank_ignored", pulses, 0);
        hblnk_in = 1'b0; vblnk_in = 1'b0;
        tick(); tick();

        // Randomized table rewrite and lookups
        for (int i = 0; i < 6; i++) begin
            write_cfg(1'b1, $urandom_range(0, BANDS - 1), 12'($urandom_range(0, 4095)),
                      12'($urandom), (i == 5), "wr_rand");
        end
        vblank_copy("copy_rand");
        for (int i = 0; i < 8; i++) begin
            v = 12'($urandom_range(0, 4095));
            scan_line(v, "scan_rand");
        end

        // Reset in the middle of a copy
        write_cfg(1'b1, 0, 12'd5, 12'h123, 1'b1, "wr_rstc");
        vblnk_in = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (commit_done) seen = 1'b1;
        end
        rst = 1'b1; vblnk_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (commit_done) seen = 1'b1;
        end
        check("rstcopy_ready_in_rst", 32'(cfg_ready), 32'd0);
        rst = 1'b0;
        model_reset();
        tick();
        check("rstcopy_ready", 32'(cfg_ready), 32'd1);
        for (int c = 0; c < 25; c++) begin
            tick();
            if (commit_done) seen = 1'b1;
        end
        check("rstcopy_no_done", 32'(seen), 32'd0);
        scan_line(12'd462, "rst_scan462");
        scan_line(12'd5, "rst_scan5");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
